// File: rtl/fpu_host_ctrl_pkg.sv
// Shared definitions for the FPU host controller: register map, FSM states,
// opcodes and the byte-lane helper used to serialise the operand writes.
package pa_fpu;

  localparam logic [5:0] A_ADDR   = 6'h00;
  localparam logic [5:0] B_ADDR   = 6'h04;
  localparam logic [5:0] OP_ADDR  = 6'h08;
  localparam logic [5:0] RES_ADDR = 6'h10;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int unsigned ACK_RETRY_CYCLES = 16;

  localparam logic [7:0] op_add = 8'h01;
  localparam logic [7:0] op_sub = 8'h02;
  localparam logic [7:0] op_mul = 8'h03;
  localparam logic [7:0] op_div = 8'h04;

  typedef enum logic [3:0] {
    IDLE,
    WR_STB,
    WR_GAP,
    WAIT_END,
    RD_STB1,
    RD_STB2,
    RD_GAP,
    ACK,
    ACK_WAIT,
    DONE
  } state_e;

  // Byte index 0..3 -> A, 4..7 -> B (LSB first), 8 -> opcode.
  function automatic logic [7:0] wr_byte(input logic [31:0] a, input logic [31:0] b,
                                         input logic [7:0] op, input logic [3:0] idx);
    logic [7:0] v;
    if (idx[3])      v = op;
    else if (idx[2]) v = b[8*idx[1:0] +: 8];
    else             v = a[8*idx[1:0] +: 8];
    return v;
  endfunction

endpackage

// File: rtl/fpu_host_ctrl_if.sv
// Byte-wide FPU register bus between the host controller (master) and the FPU (slave).
interface fpu_host_ctrl_if;
  logic [5:0] addr;
  logic [7:0] databus_out;
  logic [7:0] databus_in;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       end_ack;
  logic       cmd_end;
  logic       busy;

  modport master (
    output addr, databus_out, cs, rd, wr, end_ack,
    input  databus_in, cmd_end, busy
  );

  modport slave (
    input  addr, databus_out, cs, rd, wr, end_ack,
    output databus_in, cmd_end, busy
  );
endinterface

// File: rtl/fpu_host_ctrl_bus_strobe.sv
// Registered bus strobe generator: decodes the controller's next state so that
// cs/rd/wr/addr/data line up with the state register without combinational glitches.
module fpu_bus_strobe
  import pa_fpu::*;
(
  input  logic       clk,
  input  logic       arst,
  input  state_e     state_d_i,
  input  logic [5:0] addr_d_i,
  input  logic [7:0] wdata_d_i,
  output logic       cs_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic [5:0] addr_o,
  output logic [7:0] dout_o
);

  logic       cs_d, rd_d, wr_d;
  logic [5:0] addr_d;
  logic [7:0] dout_d;
  logic       cs_q, rd_q, wr_q;
  logic [5:0] addr_q;
  logic [7:0] dout_q;

  always_comb begin
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    addr_d = '0;
    dout_d = '0;
    unique case (state_d_i)
      WR_STB: begin
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        addr_d = addr_d_i;
        dout_d = wdata_d_i;
      end
      WR_GAP: begin
        addr_d = addr_d_i;
        dout_d = wdata_d_i;
      end
      RD_STB1, RD_STB2: begin
        cs_d   = 1'b0;
        rd_d   = 1'b0;
        addr_d = addr_d_i;
      end
      RD_GAP:  addr_d = addr_d_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cs_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      cs_q   <= cs_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
    end
  end

  assign cs_o   = cs_q;
  assign rd_o   = rd_q;
  assign wr_o   = wr_q;
  assign addr_o = addr_q;
  assign dout_o = dout_q;

endmodule

// File: rtl/fpu_host_ctrl.sv
// Host-side sequencer for a byte-wide FPU: writes A, B and opcode, waits for
// cmd_end (with timeout), reads back the result and completes the end handshake.
module fpu_host_ctrl
  import pa_fpu::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   start,
  input  logic [31:0]            operand_a,
  input  logic [31:0]            operand_b,
  input  logic [7:0]             op,
  output logic                   ready,
  output logic                   done,
  output logic                   timeout,
  output logic [31:0]            result,
  fpu_host_ctrl_if.master        bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [7:0]    op_q, op_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    ack_cnt_q, ack_cnt_d;
  logic          tflag_q, tflag_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   result_q, result_d;
  logic          ready_q, done_q, timeout_q, end_ack_q;
  logic [5:0]    addr_nx;
  logic [7:0]    wdata_nx;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    ack_cnt_d = ack_cnt_q;
    tflag_d   = tflag_q;
    acc_d     = acc_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: if (start && !bus.busy) begin
        a_d     = operand_a;
        b_d     = operand_b;
        op_d    = op;
        idx_d   = '0;
        tflag_d = 1'b0;
        state_d = WR_STB;
      end
      WR_STB: state_d = WR_GAP;
      WR_GAP: if (idx_q == 4'd8) begin
        tmo_d   = TW'(TIMEOUT_CYCLES);
        state_d = WAIT_END;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = WR_STB;
      end
      WAIT_END: if (bus.cmd_end) begin
        idx_d   = '0;
        state_d = RD_STB1;
      end else if (tmo_q == '0) begin
        tflag_d = 1'b1;
        acc_d   = QNAN;
        state_d = ACK;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
      RD_STB1: state_d = RD_STB2;
      RD_STB2: begin
        acc_d[8*idx_q[1:0] +: 8] = bus.databus_in;
        state_d = RD_GAP;
      end
      RD_GAP: if (idx_q == 4'd3) begin
        state_d = ACK;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = RD_STB1;
      end
      // ack_cnt counts cycles since the last end_ack pulse, including the pulse itself.
      ACK: begin
        ack_cnt_d = 4'd1;
        state_d   = ACK_WAIT;
      end
      ACK_WAIT: if (!bus.cmd_end) begin
        result_d = acc_q;
        state_d  = DONE;
      end else if (ack_cnt_q == 4'(ACK_RETRY_CYCLES - 1)) begin
        state_d = ACK;
      end else begin
        ack_cnt_d = ack_cnt_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_nx  = (state_d inside {RD_STB1, RD_STB2, RD_GAP}) ? RES_ADDR + {2'b00, idx_d}
                                                           : {2'b00, idx_d};
    wdata_nx = wr_byte(a_d, b_d, op_d, idx_d);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      ack_cnt_q <= '0;
      tflag_q   <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      end_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      ack_cnt_q <= ack_cnt_d;
      tflag_q   <= tflag_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      ready_q   <= (state_d == IDLE);
      done_q    <= (state_d == DONE);
      timeout_q <= (state_d == DONE) && tflag_d;
      end_ack_q <= (state_d == ACK);
    end
  end

  fpu_bus_strobe u_strobe (
    .clk       (clk),
    .arst      (arst),
    .state_d_i (state_d),
    .addr_d_i  (addr_nx),
    .wdata_d_i (wdata_nx),
    .cs_o      (bus.cs),
    .rd_o      (bus.rd),
    .wr_o      (bus.wr),
    .addr_o    (bus.addr),
    .dout_o    (bus.databus_out)
  );

  assign bus.end_ack = end_ack_q;
  assign ready       = ready_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign result      = result_q;

endmodule
